// File: rtl/reptile_core_p_if.sv
// Memory bus between reptile_core_p (master) and its RAM (slave).
// Read data is combinational from address; memwt qualifies a same-cycle write.
interface reptile_core_p_if #(
  parameter int DW = 16,
  parameter int AW = 12
);
  logic [DW-1:0] data_in;
  logic          mem_ready;
  logic [DW-1:0] data_out;
  logic [AW-1:0] address;
  logic          memwt;

  modport master (input data_in, mem_ready, output data_out, address, memwt);
  modport slave  (output data_in, mem_ready, input data_out, address, memwt);
endinterface

// File: rtl/reptile_core_p.sv
// Multi-cycle 8-register RISC core with carry flag, hardware return stack,
// mem_ready wait handshake and a sticky fault that halts until reset.
module reptile_core_p #(
  parameter int DW     = 16,
  parameter int AW     = 12,
  parameter int SDEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  reptile_core_p_if.master  bus,
  output logic [DW-1:0]     reg0,
  output logic              zero_o,
  output logic              carry_o,
  output logic              fault
);
  localparam int SPW = $clog2(SDEPTH) + 1;

  typedef enum logic [3:0] {
    S_FETCH, S_LDI, S_LD, S_ST, S_JMP, S_CALL, S_RET, S_ALU, S_HALT
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [11:0]   ir_q, ir_d;
  logic          zero_q, zero_d;
  logic          carry_q, carry_d;
  logic          fault_q, fault_d;
  logic [SPW-1:0] sp_q, sp_d;
  logic [DW-1:0] regs_q [8];
  logic [DW-1:0] regs_d [8];
  logic [AW-1:0] stack_q [SDEPTH];
  logic [AW-1:0] stack_d [SDEPTH];

  logic [DW-1:0]  op_a, op_b;
  logic [DW:0]    alu_res;
  logic [SPW-2:0] sp_top;
  logic [AW-1:0]  mem_addr;
  logic           mem_wt;

  // Bit DW of the returned value is the new carry; ops that leave carry alone pass cin through.
  function automatic logic [DW:0] alu_f(input logic [2:0] op, input logic [2:0] sub,
                                        input logic [DW-1:0] a, input logic [DW-1:0] b,
                                        input logic cin);
    logic [DW:0] r;
    r = {cin, {DW{1'b0}}};
    case (op)
      3'd0: r = {1'b0, a} + {1'b0, b};
      3'd1: r = {1'b0, a} - {1'b0, b};
      3'd2: r = {cin, a & b};
      3'd3: r = {cin, a | b};
      3'd4: r = {cin, a ^ b};
      3'd5: r = {a, 1'b0};
      3'd6: r = {a[0], 1'b0, a[DW-1:1]};
      default: begin
        case (sub)
          3'd0:    r = {cin, ~b};
          3'd1:    r = {cin, b};
          3'd2:    r = {1'b0, b} + (DW+1)'(1);
          3'd3:    r = {1'b0, b} - (DW+1)'(1);
          default: r = {cin, {DW{1'b0}}};
        endcase
      end
    endcase
    return r;
  endfunction

  assign op_a    = regs_q[ir_q[8:6]];
  assign op_b    = regs_q[ir_q[5:3]];
  assign alu_res = alu_f(ir_q[11:9], ir_q[8:6], op_a, op_b, carry_q);
  assign sp_top  = sp_q[SPW-2:0] - (SPW-1)'(1);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    fault_d  = fault_q;
    sp_d     = sp_q;
    regs_d   = regs_q;
    stack_d  = stack_q;
    mem_addr = pc_q;
    mem_wt   = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (bus.mem_ready) begin
          ir_d = bus.data_in[11:0];
          pc_d = pc_q + AW'(1);
          case (bus.data_in[15:12])
            4'h1:    state_d = S_LDI;
            4'h2:    state_d = S_LD;
            4'h3:    state_d = S_ST;
            4'h4:    state_d = zero_q ? S_JMP : S_FETCH;
            4'h5:    state_d = S_JMP;
            4'h6:    state_d = bus.data_in[11] ? S_RET : S_CALL;
            4'h7:    state_d = S_ALU;
            4'h8:    state_d = carry_q ? S_JMP : S_FETCH;
            default: state_d = S_FETCH;
          endcase
        end
      end
      S_LDI: begin
        if (bus.mem_ready) begin
          regs_d[ir_q[2:0]] = bus.data_in;
          pc_d              = pc_q + AW'(1);
          state_d           = S_FETCH;
        end
      end
      S_LD: begin
        mem_addr = op_b[AW-1:0];
        if (bus.mem_ready) begin
          regs_d[ir_q[2:0]] = bus.data_in;
          state_d           = S_FETCH;
        end
      end
      S_ST: begin
        mem_addr = op_b[AW-1:0];
        if (bus.mem_ready) begin
          mem_wt  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_JMP: begin
        // pc already points past the branch word; offset is relative to that
        pc_d    = pc_q + AW'($signed(ir_q));
        state_d = S_FETCH;
      end
      S_CALL: begin
        if (sp_q == SPW'(SDEPTH)) begin
          fault_d = 1'b1;
          state_d = S_HALT;
        end else begin
          stack_d[sp_q[SPW-2:0]] = pc_q;
          sp_d    = sp_q + SPW'(1);
          pc_d    = pc_q + AW'($signed(ir_q[10:0]));
          state_d = S_FETCH;
        end
      end
      S_RET: begin
        if (sp_q == '0) begin
          fault_d = 1'b1;
          state_d = S_HALT;
        end else begin
          pc_d    = stack_q[sp_top];
          sp_d    = sp_q - SPW'(1);
          state_d = S_FETCH;
        end
      end
      S_ALU: begin
        regs_d[ir_q[2:0]] = alu_res[DW-1:0];
        zero_d  = (alu_res[DW-1:0] == '0);
        carry_d = alu_res[DW];
        state_d = S_FETCH;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      fault_q <= 1'b0;
      sp_q    <= '0;
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      fault_q <= fault_d;
      sp_q    <= sp_d;
      regs_q  <= regs_d;
    end
  end

  // Stack entries are only meaningful below sp, so they carry no reset.
  always_ff @(posedge clk) begin
    stack_q <= stack_d;
  end

  assign bus.address  = mem_addr;
  assign bus.memwt    = mem_wt;
  assign bus.data_out = op_a;
  assign reg0         = regs_q[0];
  assign zero_o       = zero_q;
  assign carry_o      = carry_q;
  assign fault        = fault_q;
endmodule

// File: tb/tb_reptile_core_p.sv
// Bench for reptile_core_p: an instruction-level model predicts every store,
// which a bus monitor checks as the core performs them, plus end-of-program state.
module tb_reptile_core_p;
  localparam int DW = 16, AW = 12, SDEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;
  logic load_en = 1'b0;
  logic stall_en = 1'b0;
  logic ready_man = 1'b1;
  logic [DW-1:0] reg0;
  logic zero_o, carry_o, fault;

  always #5 clk = ~clk;

  reptile_core_p_if #(.DW(DW), .AW(AW)) bus ();

  reptile_core_p #(.DW(DW), .AW(AW), .SDEPTH(SDEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus), .reg0(reg0),
    .zero_o(zero_o), .carry_o(carry_o), .fault(fault)
  );

  logic [DW-1:0] ram [4096];
  logic [DW-1:0] img [4096];

  assign bus.data_in   = ram[bus.address];
  assign bus.mem_ready = rdy;

  always @(posedge clk) begin
    if (load_en) ram <= img;
    else if (bus.memwt === 1'b1) ram[bus.address] <= bus.data_out;
  end

  typedef struct packed { logic [11:0] a; logic [15:0] d; } st_t;
  st_t exp_q[$];
  st_t mon_e;
  int errors = 0, checks = 0, wt_cnt = 0, wp = 0;
  int m_pc, m_reg0, m_z, m_c, m_flt;

  task automatic check(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && bus.memwt === 1'b1) begin
      wt_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL store_unexpected: addr 0x%0h data 0x%0h, no store expected",
                 bus.address, bus.data_out);
      end else begin
        mon_e = exp_q.pop_front();
        check("store_addr", int'(bus.address), int'(mon_e.a));
        check("store_data", int'(bus.data_out), int'(mon_e.d));
      end
    end
  end

  function automatic int sx(int v, int n);
    int t;
    t = v & ((1 << n) - 1);
    if (t >= (1 << (n - 1))) t -= (1 << n);
    return t;
  endfunction

  // Architectural model: executes the image word by word, logging stores.
  task automatic model_run();
    int mm[4096];
    int r[8];
    int stk[$];
    int pc, w, op, ir, a, b, res, s, sub, z, c, flt;
    st_t e;
    for (int i = 0; i < 4096; i++) mm[i] = int'(img[i]);
    for (int i = 0; i < 8; i++) r[i] = 0;
    pc = 0; z = 0; c = 0; flt = 0;
    for (int n = 0; n < 20000; n++) begin
      w = mm[pc]; pc = (pc + 1) & 4095; op = w >> 12; ir = w & 4095;
      if (op == 1) begin
        r[ir & 7] = mm[pc]; pc = (pc + 1) & 4095;
      end else if (op == 2) begin
        r[ir & 7] = mm[r[(ir >> 3) & 7] & 4095];
      end else if (op == 3) begin
        a = r[(ir >> 3) & 7] & 4095;
        mm[a] = r[(ir >> 6) & 7];
        e.a = a[11:0]; e.d = mm[a][15:0];
        exp_q.push_back(e);
      end else if ((op == 4 && z != 0) || op == 5 || (op == 8 && c != 0)) begin
        pc = (pc + sx(ir, 12)) & 4095;
      end else if (op == 6) begin
        if (ir >= 2048) begin
          if (stk.size() == 0) begin flt = 1; break; end
          pc = stk.pop_back();
        end else begin
          if (stk.size() == SDEPTH) begin flt = 1; break; end
          stk.push_back(pc);
          pc = (pc + sx(ir, 11)) & 4095;
        end
      end else if (op == 7) begin
        a = r[(ir >> 6) & 7]; b = r[(ir >> 3) & 7]; sub = (ir >> 6) & 7;
        case ((ir >> 9) & 7)
          0: begin s = a + b; res = s & 65535; c = (s > 65535) ? 1 : 0; end
          1: begin res = (a - b) & 65535; c = (a < b) ? 1 : 0; end
          2: res = a & b;
          3: res = a | b;
          4: res = a ^ b;
          5: begin c = (a >= 32768) ? 1 : 0; res = (a * 2) & 65535; end
          6: begin c = a % 2; res = a / 2; end
          default: begin
            case (sub)
              0: res = 65535 - b;
              1: res = b;
              2: begin res = (b + 1) & 65535; c = (b == 65535) ? 1 : 0; end
              3: begin res = (b + 65535) & 65535; c = (b == 0) ? 1 : 0; end
              default: res = 0;
            endcase
          end
        endcase
        r[ir & 7] = res;
        z = (res == 0) ? 1 : 0;
      end
    end
    m_pc = pc; m_reg0 = r[0]; m_z = z; m_c = c; m_flt = flt;
  endtask

  function automatic int f_ldi(int rd);           return 'h1000 | rd; endfunction
  function automatic int f_ld(int rd, int ra);    return 'h2000 | (ra << 3) | rd; endfunction
  function automatic int f_st(int rs, int ra);    return 'h3000 | (rs << 6) | (ra << 3); endfunction
  function automatic int f_br(int opc, int off);  return (opc << 12) | (off & 4095); endfunction
  function automatic int f_alu(int op, int a, int b, int d);
    return 'h7000 | (op << 9) | (a << 6) | (b << 3) | d;
  endfunction
  function automatic int f_call(int off); return 'h6000 | (off & 2047); endfunction
  localparam int RET_W = 'h6800;

  function automatic int pickval();
    case ($urandom_range(0, 4))
      0: return 0;
      1: return 'hFFFF;
      2: return 'h8000;
      3: return 1;
      default: return int'($urandom_range(0, 65535));
    endcase
  endfunction

  function automatic int rand_alu();
    return f_alu(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 6)));
  endfunction

  task automatic emit(int w);
    img[wp] = w[15:0];
    wp++;
  endtask

  task automatic clear_img();
    for (int i = 0; i < 4096; i++) img[i] = '0;
    for (int i = 'h800; i < 'h900; i++) img[i] = 16'($urandom_range(0, 65535));
    wp = 0;
  endtask

  task automatic gen_random();
    int k, rd;
    clear_img();
    emit(f_ldi(7)); emit('h800 + int'($urandom_range(0, 255)));
    for (int i = 0; i < 7; i++) begin emit(f_ldi(i)); emit(pickval()); end
    repeat (40) begin
      k = int'($urandom_range(0, 7));
      case (k)
        0, 1: emit(rand_alu());
        2: emit(f_st(int'($urandom_range(0, 7)), 7));
        3: emit(f_ld(int'($urandom_range(0, 6)), 7));
        4: begin emit(f_br(4, 1)); emit(rand_alu()); end
        5: begin emit(f_br(8, 1)); emit(rand_alu()); end
        6: begin emit(f_call(1)); emit(f_br(5, 2)); emit(rand_alu()); emit(RET_W); end
        default: begin
          rd = int'($urandom_range(0, 7));
          emit(f_ldi(rd));
          emit(rd == 7 ? 'h800 + int'($urandom_range(0, 255)) : pickval());
        end
      endcase
    end
    for (int i = 0; i < 7; i++) emit(f_st(i, 7));
    emit(RET_W);
  endtask

  task automatic gen_nest(int depth);
    clear_img();
    emit(f_ldi(7)); emit('h800);
    for (int i = 0; i < depth; i++) begin
      emit(f_alu(7, 2, 0, 0)); emit(f_call(2)); emit(f_st(0, 7)); emit(RET_W);
    end
    emit(f_alu(7, 2, 0, 0)); emit(f_st(0, 7)); emit(RET_W);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    rdy = stall_en ? ($urandom_range(0, 3) != 0) : ready_man;
  endtask

  task automatic start_prog();
    rst = 1'b1;
    exp_q.delete();
    wt_cnt = 0;
    load_en = 1'b1;
    step();
    load_en = 1'b0;
    step();
    check("rst_address", int'(bus.address), 0);
    check("rst_memwt", int'(bus.memwt), 0);
    check("rst_data_out", int'(bus.data_out), 0);
    check("rst_reg0", int'(reg0), 0);
    check("rst_flags", int'({zero_o, carry_o, fault}), 0);
    model_run();
    rst = 1'b0;
  endtask

  task automatic finish_prog(string nm);
    int cyc;
    cyc = 0;
    while (fault !== 1'b1 && cyc < 4000) begin step(); cyc++; end
    check({nm, "_fault"}, int'(fault === 1'b1), m_flt);
    repeat (3) step();
    check({nm, "_halt_pc"}, int'(bus.address), m_pc);
    check({nm, "_halt_memwt"}, int'(bus.memwt), 0);
    check({nm, "_reg0"}, int'(reg0), m_reg0);
    check({nm, "_zero"}, int'(zero_o), m_z);
    check({nm, "_carry"}, int'(carry_o), m_c);
    check({nm, "_pending_stores"}, exp_q.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // LDI latency, add with carry-out, taken JC
    clear_img();
    emit(f_ldi(0)); emit('h1234); emit(f_ldi(7)); emit('h800);
    emit(f_ldi(1)); emit('hFFFF); emit(f_ldi(2)); emit(1);
    emit(f_alu(0, 1, 2, 0)); emit(f_br(8, 2)); emit(f_ldi(0)); emit('h5555);
    emit(f_st(0, 7)); emit(RET_W);
    start_prog();
    step();
    check("ldi_cyc1_reg0", int'(reg0), 0);
    step();
    check("ldi_cyc2_reg0", int'(reg0), 'h1234);
    check("ldi_cyc2_pc", int'(bus.address), 2);
    finish_prog("arith");
    check("add_reg0", int'(reg0), 0);
    check("add_zero", int'(zero_o), 1);
    check("add_carry", int'(carry_o), 1);
    check("jc_halt_pc", int'(bus.address), 14);

    // LD stalled five cycles by mem_ready
    clear_img();
    emit(f_ldi(7)); emit('h800); emit(f_ld(0, 7)); emit(f_st(0, 7)); emit(RET_W);
    img['h800] = 16'hBEEF;
    start_prog();
    step(); step();
    ready_man = 1'b0;
    step();
    for (int k = 0; k < 5; k++) begin
      check("stall_address", int'(bus.address), 'h800);
      check("stall_reg0", int'(reg0), 0);
      if (k == 4) ready_man = 1'b1;
      step();
    end
    check("stall_reg0_last", int'(reg0), 0);
    step();
    check("stall_ld_done", int'(reg0), 'hBEEF);
    finish_prog("stall");

    // single-cycle store strobe
    clear_img();
    emit(f_ldi(3)); emit('hA5C3); emit(f_ldi(4)); emit('h07F); emit(f_st(3, 4)); emit(RET_W);
    start_prog();
    finish_prog("store");
    check("st_pulses", wt_cnt, 1);
    check("st_ram_07f", int'(ram['h07F]), 'hA5C3);

    // return stack full depth, then one call too many
    gen_nest(SDEPTH);
    start_prog();
    finish_prog("nest_full");
    check("nest_full_stores", wt_cnt, SDEPTH + 1);
    check("nest_full_reg0", int'(reg0), SDEPTH + 1);
    gen_nest(SDEPTH + 1);
    start_prog();
    finish_prog("nest_over");
    check("nest_over_stores", wt_cnt, 0);

    // RET on empty stack, then recovery through reset
    clear_img();
    emit(RET_W);
    start_prog();
    finish_prog("ret_empty");
    check("ret_empty_pc", int'(bus.address), 1);
    rst = 1'b1;
    step();
    check("recover_fault", int'(fault), 0);
    check("recover_pc", int'(bus.address), 0);
    rst = 1'b0;
    step();
    check("recover_fetch", int'(bus.address), 1);

    // randomized programs, most with random wait states
    for (int n = 0; n < 6; n++) begin
      stall_en = (n != 0);
      gen_random();
      start_prog();
      finish_prog("rand");
    end
    stall_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
